pattern_sequencer: RTL and testbench

Parametrised, programmable pattern sequencer: plays a stored table of DATA_W-bit words out over a valid/ready stream, either one-shot or looping. It is the next generation of the fixed 8-entry sequence generator, generalised in width and depth, with a runtime-loadable table and proper back-pressure. It sits between test-pattern control registers and any streaming consumer.

---
 rtl/pattern_sequencer_pkg.sv | 20 ++
 rtl/pattern_table.sv | 51 +++++
 rtl/pattern_sequencer.sv | 139 +++++++++++++
 tb/tb_pattern_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_pkg.sv
// Shared constants for the pattern sequencer slice.
// Default table contents, FSM state encodings and loop counter width.
package pattern_sequencer_pkg;

  localparam logic [63:0] DEFAULT_PATTERN = 64'hAFBC_E278_FFE2_0B8D;

  localparam int LOOP_CNT_W = 16;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  // Entry 0 lives in the top byte of DEFAULT_PATTERN.
  function automatic logic [7:0] default_byte(input int unsigned i);
    int unsigned k;
    k = i % 8;
    return DEFAULT_PATTERN[63-8*k -: 8];
  endfunction

endpackage

// File: rtl/pattern_table.sv
// Pattern storage: default ROM, or a writable register file when
// PATTERN_SEQUENCER_PROG_EN is defined. Combinational read port.
module pattern_table
  import pattern_sequencer_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Default byte truncated or zero-extended to the word width.
  function automatic logic [DATA_W-1:0] dflt(input int unsigned i);
    logic [39:0] w;
    w = {32'd0, default_byte(i)};
    return w[DATA_W-1:0];
  endfunction

`ifdef PATTERN_SEQUENCER_PROG_EN
  logic [DATA_W-1:0] mem [DEPTH];

  // Table registers: defaults on reset, written any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= dflt(32'(i));
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, wr_en, wr_addr, wr_data};

  // Constant default mapping.
  always_comb begin
    rd_data = dflt(32'(rd_addr));
  end
`endif

endmodule

// File: rtl/pattern_sequencer.sv
// Programmable pattern sequencer: plays a table over valid/ready.
// Optional table write port: PATTERN_SEQUENCER_PROG_EN.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_mode,
  input  logic [ADDR_W:0]       seq_len,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [LOOP_CNT_W-1:0] loop_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic              mode;

  logic              hs;
  logic              at_end;
  logic [ADDR_W:0]   clen;
  logic [ADDR_W-1:0] nxt_idx;
  logic              nxt_last;
  logic [DATA_W-1:0] rd_data;

  assign hs     = out_valid & out_ready;
  assign at_end = ({1'b0, idx} == len - 1'b1);
  assign busy   = (state != IDLE);

  assign clen = ((seq_len == '0) || (seq_len > DEPTH_L)) ? DEPTH_L : seq_len;

  // Next index: entry 0 on start or wrap, else advance on handshake.
  always_comb begin
    nxt_idx  = idx;
    nxt_last = 1'b0;
    if (state == IDLE) begin
      nxt_idx  = '0;
      nxt_last = (clen == 1);
    end else begin
      if (hs) begin
        nxt_idx = at_end ? '0 : idx + 1'b1;
      end
      nxt_last = ({1'b0, nxt_idx} == len - 1'b1);
    end
  end

  pattern_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (nxt_idx),
    .rd_data (rd_data)
  );

  // Playback FSM with index, loop counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      loop_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            len       <= clen;
            mode      <= loop_mode;
            idx       <= '0;
            out_data  <= rd_data;
            out_last  <= nxt_last;
            out_valid <= 1'b1;
            loop_cnt  <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            idx      <= nxt_idx;
            out_data <= rd_data;
            out_last <= nxt_last;
            if (at_end && mode && (loop_cnt != '1)) begin
              loop_cnt <= loop_cnt + 1'b1;
            end
          end
          if (stop) begin
            if (hs) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              state <= STOPPING;
            end
          end else if (hs && at_end && !mode) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        STOPPING: begin
          if (hs) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer (DATA_W=8, DEPTH=8).
// Expected words are the default pattern written out by hand.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_mode = 1'b0;
  logic [3:0]  seq_len = 4'd0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] loop_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] pat [8];
  logic [7:0] exp2;

  always #5 clk = ~clk;

  pattern_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .seq_len   (seq_len),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .loop_cnt  (loop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic lm, input logic [3:0] len);
    loop_mode = lm;
    seq_len   = len;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] d,
                      input logic l);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, out_last, l);
    tick();
  endtask

  initial begin
    pat = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
`ifdef PATTERN_SEQUENCER_PROG_EN
    exp2 = 8'h55;
`else
    exp2 = 8'hE2;
`endif

    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_loop_cnt", loop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // one-shot, full table, ready held high
    kick(1'b0, 4'd8);
    for (int k = 0; k < 8; k++) begin
      beat($sformatf("os_b%0d", k), pat[k], k == 7);
    end
    check("os_valid_end", out_valid, 0);
    check("os_busy_end", busy, 0);

    // one-shot with a 3-cycle stall at the third beat
    kick(1'b0, 4'd8);
    beat("st_b0", pat[0], 0);
    beat("st_b1", pat[1], 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("st_hold%0d_data", k), out_data, 8'hE2);
      check($sformatf("st_hold%0d_valid", k), out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      beat($sformatf("st_b%0d", k), pat[k], k == 7);
    end
    check("st_valid_end", out_valid, 0);

    // loop mode, length 3, then stop while stalled
    kick(1'b1, 4'd3);
    for (int p = 1; p <= 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        beat($sformatf("lp_p%0d_b%0d", p, k), pat[k], k == 2);
      end
      check($sformatf("lp_cnt%0d", p), loop_cnt, p);
    end
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sp_busy", busy, 1);
    check("sp_valid", out_valid, 1);
    check("sp_data", out_data, 8'hAF);
    tick();
    check("sp_hold_data", out_data, 8'hAF);
    out_ready = 1'b1;
    tick();
    check("sp_valid_end", out_valid, 0);
    check("sp_busy_end", busy, 0);
    check("sp_loop_cnt", loop_cnt, 2);

    // table write then one-shot length 4
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    kick(1'b0, 4'd4);
    beat("wr_b0", 8'hAF, 0);
    beat("wr_b1", 8'hBC, 0);
    beat("wr_b2", exp2, 0);
    beat("wr_b3", 8'h78, 1);
    check("wr_valid_end", out_valid, 0);

    // seq_len 0 clamps to DEPTH; start during RUN ignored
    kick(1'b0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) start = 1'b1;
      beat($sformatf("cl_b%0d", k), (k == 2) ? exp2 : pat[k], k == 7);
      start = 1'b0;
    end
    check("cl_valid_end", out_valid, 0);
    check("cl_busy_end", busy, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_valid", out_valid, 0);

    // async reset during beat 4 of a looping run
    kick(1'b1, 4'd3);
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("ar_b%0d", k), pat[k], k == 2);
    end
    check("ar_cnt_pre", loop_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_loop_cnt", loop_cnt, 0);
    check("ar_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    tick();
    kick(1'b0, 4'd4);
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("pr_b%0d", k), pat[k], k == 3);
    end
    check("pr_valid_end", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
